// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with byte strobes, read-only hardware-fed registers,
// SLVERR decode and per-register write/read strobes for the downstream engine.
module axi_lite_regbank #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_REGS   = 4,
   parameter int                    ADDR_WIDTH = 6,
   parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                     S_AXI_AWPROT,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                     S_AXI_ARPROT,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
   output logic [NUM_REGS-1:0]            wr_pulse,
   output logic [NUM_REGS-1:0]            rd_pulse
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

   logic                  r_awSeen;
   logic                  r_wSeen;
   logic [IDX_W-1:0]      r_awIdx;
   logic [DATA_WIDTH-1:0] r_wData;
   logic [STRB_W-1:0]     r_wStrb;
   logic                  r_bValid;
   logic [1:0]            r_bResp;
   logic                  r_rValid;
   logic [1:0]            r_rResp;
   logic [DATA_WIDTH-1:0] r_rData;
   logic [NUM_REGS-1:0]   r_wrPulse;
   logic [NUM_REGS-1:0]   r_rdPulse;

   logic                  w_awHs;
   logic                  w_wHs;
   logic                  w_arHs;
   logic                  w_commit;
   logic [IDX_W-1:0]      w_wrIdx;
   logic [IDX_W-1:0]      w_rdIdx;
   logic [DATA_WIDTH-1:0] w_wrData;
   logic [STRB_W-1:0]     w_wrStrb;
   logic [NUM_REGS-1:0]   w_wrSel;
   logic [NUM_REGS-1:0]   w_rdSel;
   logic                  w_wrOk;
   logic                  w_rdOk;
   logic [DATA_WIDTH-1:0] w_rdData;
   wire  [NUM_REGS*DATA_WIDTH-1:0] w_regOut;
   logic                  w_unused;

   assign S_AXI_AWREADY = !ARESET && !r_awSeen && !r_bValid;
   assign S_AXI_WREADY  = !ARESET && !r_wSeen && !r_bValid;
   assign S_AXI_ARREADY = !ARESET && !r_rValid;

   assign w_awHs   = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_wHs    = S_AXI_WVALID && S_AXI_WREADY;
   assign w_arHs   = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_commit = (r_awSeen || w_awHs) && (r_wSeen || w_wHs);

   // The commit may use a freshly handshaken beat or one captured on an earlier edge.
   assign w_wrIdx  = r_awSeen ? r_awIdx : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
   assign w_wrData = r_wSeen ? r_wData : S_AXI_WDATA;
   assign w_wrStrb = r_wSeen ? r_wStrb : S_AXI_WSTRB;
   assign w_rdIdx  = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0], hw_in};

   always_comb begin
      w_wrSel  = '0;
      w_rdSel  = '0;
      w_wrOk   = 1'b0;
      w_rdOk   = 1'b0;
      w_rdData = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(w_wrIdx) == i) begin
            w_wrSel[i] = 1'b1;
            w_wrOk     = !RO_MASK[i];
         end
         if (int'(w_rdIdx) == i) begin
            w_rdSel[i] = 1'b1;
            w_rdOk     = 1'b1;
            w_rdData   = w_regOut[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : gReg
      if (RO_MASK[g]) begin : gRo
         assign w_regOut[g*DATA_WIDTH +: DATA_WIDTH] = hw_in[g*DATA_WIDTH +: DATA_WIDTH];
      end else begin : gRw
         logic [DATA_WIDTH-1:0] r_value;

         always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
               r_value <= RESET_VAL;
            end else if (w_commit && w_wrOk && w_wrSel[g]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (w_wrStrb[b]) begin
                     r_value[b*8 +: 8] <= w_wrData[b*8 +: 8];
                  end
               end
            end
         end

         assign w_regOut[g*DATA_WIDTH +: DATA_WIDTH] = r_value;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_awSeen  <= 1'b0;
         r_wSeen   <= 1'b0;
         r_awIdx   <= '0;
         r_wData   <= '0;
         r_wStrb   <= '0;
         r_bValid  <= 1'b0;
         r_bResp   <= 2'b00;
         r_wrPulse <= '0;
      end else begin
         r_wrPulse <= (w_commit && w_wrOk) ? w_wrSel : '0;
         if (w_awHs) begin
            r_awIdx <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
         end
         if (w_wHs) begin
            r_wData <= S_AXI_WDATA;
            r_wStrb <= S_AXI_WSTRB;
         end
         if (w_commit) begin
            r_awSeen <= 1'b0;
            r_wSeen  <= 1'b0;
            r_bValid <= 1'b1;
            r_bResp  <= w_wrOk ? 2'b00 : 2'b10;
         end else begin
            if (w_awHs) begin
               r_awSeen <= 1'b1;
            end
            if (w_wHs) begin
               r_wSeen <= 1'b1;
            end
            if (r_bValid && S_AXI_BREADY) begin
               r_bValid <= 1'b0;
            end
         end
      end
   end

   // Read data is captured from the pre-edge register view, so a same-edge write is not visible.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rValid  <= 1'b0;
         r_rResp   <= 2'b00;
         r_rData   <= '0;
         r_rdPulse <= '0;
      end else begin
         r_rdPulse <= w_arHs ? w_rdSel : '0;
         if (w_arHs) begin
            r_rValid <= 1'b1;
            r_rData  <= w_rdData;
            r_rResp  <= w_rdOk ? 2'b00 : 2'b10;
         end else if (r_rValid && S_AXI_RREADY) begin
            r_rValid <= 1'b0;
         end
      end
   end

   assign S_AXI_BVALID = r_bValid;
   assign S_AXI_BRESP  = r_bResp;
   assign S_AXI_RVALID = r_rValid;
   assign S_AXI_RRESP  = r_rResp;
   assign S_AXI_RDATA  = r_rData;
   assign reg_out      = w_regOut;
   assign wr_pulse     = r_wrPulse;
   assign rd_pulse     = r_rdPulse;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Scoreboard bench for axi_lite_regbank: 4 x 32-bit registers, reg2 read-only from hw_in.
module tb_axi_lite_regbank;

   localparam logic [31:0] RST_VAL = 32'h0000_A5A5;

   logic         aclk = 1'b0;
   logic         areset = 1'b1;
   logic [5:0]   awAddr = '0;
   logic         awValid = 1'b0;
   logic         awReady;
   logic [31:0]  wData = '0;
   logic [3:0]   wStrb = '0;
   logic         wValid = 1'b0;
   logic         wReady;
   logic [1:0]   bResp;
   logic         bValid;
   logic         bReady = 1'b1;
   logic [5:0]   arAddr = '0;
   logic         arValid = 1'b0;
   logic         arReady;
   logic [31:0]  rData;
   logic [1:0]   rResp;
   logic         rValid;
   logic         rReady = 1'b1;
   logic [127:0] regOut;
   logic [127:0] hwIn = {32'hDEAD_0003, 32'hCAFE_F00D, 32'hDEAD_0001, 32'hDEAD_0000};
   logic [3:0]   wrPulse;
   logic [3:0]   rdPulse;

   int nChecks = 0;
   int nFails  = 0;

   logic [1:0]  bExp[$];
   logic [33:0] rExp[$];

   axi_lite_regbank #(
      .DATA_WIDTH(32), .NUM_REGS(4), .ADDR_WIDTH(6),
      .RO_MASK(4'b0100), .RESET_VAL(RST_VAL)
   ) dut (
      .ACLK(aclk), .ARESET(areset),
      .S_AXI_AWADDR(awAddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awValid), .S_AXI_AWREADY(awReady),
      .S_AXI_WDATA(wData), .S_AXI_WSTRB(wStrb), .S_AXI_WVALID(wValid), .S_AXI_WREADY(wReady),
      .S_AXI_BRESP(bResp), .S_AXI_BVALID(bValid), .S_AXI_BREADY(bReady),
      .S_AXI_ARADDR(arAddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arValid), .S_AXI_ARREADY(arReady),
      .S_AXI_RDATA(rData), .S_AXI_RRESP(rResp), .S_AXI_RVALID(rValid), .S_AXI_RREADY(rReady),
      .reg_out(regOut), .hw_in(hwIn), .wr_pulse(wrPulse), .rd_pulse(rdPulse)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Responses are popped at the negedge before the handshake edge, while inputs are stable.
   always @(negedge aclk) begin
      if (!areset && bValid && bReady) begin
         if (bExp.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected B response: got 0x%0h, expected none", bResp);
         end else begin
            checkOutput("bresp", {62'd0, bResp}, {62'd0, bExp.pop_front()});
         end
      end
      if (!areset && rValid && rReady) begin
         if (rExp.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected R response: got 0x%0h, expected none", rData);
         end else begin
            logic [33:0] e;
            e = rExp.pop_front();
            checkOutput("rdata", {32'd0, rData}, {32'd0, e[33:2]});
            checkOutput("rresp", {62'd0, rResp}, {62'd0, e[1:0]});
         end
      end
   end

   task automatic waitDrained();
      for (int n = 0; n < 30 && (bExp.size() != 0 || rExp.size() != 0); n++) begin
         @(negedge aclk);
      end
      checkOutput("responses drained", 64'(bExp.size() + rExp.size()), 64'd0);
      bExp.delete();
      rExp.delete();
   endtask

   // One directed vector; for reads, data is the expected read value.
   task automatic applyStimulus(input bit isWrite, input logic [5:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] expResp, input logic [3:0] expPulse);
      bit rdy;
      if (isWrite) bExp.push_back(expResp);
      else         rExp.push_back({data, expResp});
      @(posedge aclk); #1;
      if (isWrite) begin
         awValid = 1'b1; awAddr = addr; wValid = 1'b1; wData = data; wStrb = strb;
      end else begin
         arValid = 1'b1; arAddr = addr;
      end
      rdy = 1'b0;
      for (int n = 0; n < 20 && !rdy; n++) begin
         @(negedge aclk);
         rdy = isWrite ? (awReady && wReady) : arReady;
      end
      checkOutput("ready for request", {63'd0, rdy}, 64'd1);
      @(posedge aclk); #1;
      awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
      if (isWrite) checkOutput("wr/rd pulses after write", {56'd0, wrPulse, rdPulse}, {56'd0, expPulse, 4'b0000});
      else         checkOutput("wr/rd pulses after read", {56'd0, wrPulse, rdPulse}, {56'd0, 4'b0000, expPulse});
      waitDrained();
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge aclk);
      #1;
      checkOutput("readies in reset", {61'd0, awReady, wReady, arReady}, 64'd0);
      checkOutput("valids in reset", {62'd0, bValid, rValid}, 64'd0);
      checkOutput("rdata/resps in reset", {28'd0, rData, bResp, rResp}, 64'd0);
      checkOutput("pulses in reset", {56'd0, wrPulse, rdPulse}, 64'd0);
      checkOutput("reg0 reset value", {32'd0, regOut[31:0]}, {32'd0, RST_VAL});
      checkOutput("reg2 follows hw_in", {32'd0, regOut[95:64]}, 64'hCAFE_F00D);
      @(negedge aclk);
      areset = 1'b0;
      @(posedge aclk); #1;
      checkOutput("readies after reset", {61'd0, awReady, wReady, arReady}, 64'd7);

      // Sequential write/readback; reg2 is read-only
      applyStimulus(1, 6'h00, 32'h1, 4'hF, 2'b00, 4'b0001);
      applyStimulus(1, 6'h04, 32'h2, 4'hF, 2'b00, 4'b0010);
      applyStimulus(1, 6'h08, 32'h3, 4'hF, 2'b10, 4'b0000);
      applyStimulus(1, 6'h0C, 32'h4, 4'hF, 2'b00, 4'b1000);
      applyStimulus(0, 6'h00, 32'h1, 4'h0, 2'b00, 4'b0001);
      applyStimulus(0, 6'h04, 32'h2, 4'h0, 2'b00, 4'b0010);
      applyStimulus(0, 6'h08, 32'hCAFE_F00D, 4'h0, 2'b00, 4'b0100);
      applyStimulus(0, 6'h0C, 32'h4, 4'h0, 2'b00, 4'b1000);

      // Byte strobes
      applyStimulus(1, 6'h00, 32'h1122_3344, 4'hF, 2'b00, 4'b0001);
      applyStimulus(1, 6'h00, 32'hAABB_CCDD, 4'b0101, 2'b00, 4'b0001);
      applyStimulus(0, 6'h00, 32'h11BB_33DD, 4'h0, 2'b00, 4'b0001);

      // Out of range, ignored low address bits, empty strobe
      applyStimulus(0, 6'h10, 32'h0, 4'h0, 2'b10, 4'b0000);
      applyStimulus(1, 6'h14, 32'h9999_9999, 4'hF, 2'b10, 4'b0000);
      applyStimulus(0, 6'h06, 32'h2, 4'h0, 2'b00, 4'b0010);
      applyStimulus(1, 6'h0C, 32'hFFFF_FFFF, 4'h0, 2'b00, 4'b1000);
      applyStimulus(0, 6'h0C, 32'h4, 4'h0, 2'b00, 4'b1000);

      // W two cycles ahead of AW, response held off for five cycles
      bExp.push_back(2'b00);
      bReady = 1'b0;
      @(posedge aclk); #1;
      wValid = 1'b1; wData = 32'h1234_5678; wStrb = 4'hF;
      @(posedge aclk); #1;
      wValid = 1'b0;
      checkOutput("after W only", {61'd0, awReady, wReady, bValid}, 64'b100);
      @(posedge aclk); #1;
      checkOutput("reg3 before AW", {32'd0, regOut[127:96]}, 64'h4);
      awValid = 1'b1; awAddr = 6'h0C;
      @(posedge aclk); #1;
      awValid = 1'b0;
      checkOutput("commit after AW", {59'd0, bValid, wrPulse}, {59'd0, 1'b1, 4'b1000});
      checkOutput("reg3 committed", {32'd0, regOut[127:96]}, 64'h1234_5678);
      for (int i = 0; i < 4; i++) begin
         @(posedge aclk); #1;
         checkOutput("B held, channels blocked", {55'd0, bValid, bResp, awReady, wReady, wrPulse},
                     {55'd0, 1'b1, 2'b00, 1'b0, 1'b0, 4'b0000});
      end
      bReady = 1'b1;
      waitDrained();
      @(posedge aclk); #1;
      checkOutput("B cleared after handshake", {63'd0, bValid}, 64'd0);
      applyStimulus(0, 6'h0C, 32'h1234_5678, 4'h0, 2'b00, 4'b1000);

      // Same-edge read and write to reg1
      bExp.push_back(2'b00);
      rExp.push_back({32'h2, 2'b00});
      @(posedge aclk); #1;
      awValid = 1'b1; awAddr = 6'h04; wValid = 1'b1; wData = 32'h55; wStrb = 4'hF;
      arValid = 1'b1; arAddr = 6'h04;
      @(posedge aclk); #1;
      awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
      checkOutput("concurrent pulses", {56'd0, wrPulse, rdPulse}, {56'd0, 4'b0010, 4'b0010});
      waitDrained();
      applyStimulus(0, 6'h04, 32'h55, 4'h0, 2'b00, 4'b0010);

      // Reset while both responses are pending
      bReady = 1'b0;
      rReady = 1'b0;
      @(posedge aclk); #1;
      awValid = 1'b1; awAddr = 6'h00; wValid = 1'b1; wData = 32'h99; wStrb = 4'hF;
      arValid = 1'b1; arAddr = 6'h04;
      @(posedge aclk); #1;
      awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
      checkOutput("both pending", {62'd0, bValid, rValid}, 64'b11);
      @(negedge aclk); #1;
      areset = 1'b1;
      #1;
      checkOutput("valids drop on reset", {62'd0, bValid, rValid}, 64'd0);
      checkOutput("regs back to reset value", {regOut[63:32], regOut[31:0]}, {RST_VAL, RST_VAL});
      checkOutput("rdata cleared by reset", {32'd0, rData}, 64'd0);
      @(negedge aclk);
      areset = 1'b0;
      bReady = 1'b1;
      rReady = 1'b1;
      applyStimulus(0, 6'h00, RST_VAL, 4'h0, 2'b00, 4'b0001);
      applyStimulus(0, 6'h0C, RST_VAL, 4'h0, 2'b00, 4'b1000);

      repeat (3) @(posedge aclk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It replaces the fixed four-register slave front end used by the i2c_master IP. It is generalised in register count and data width, and adds:
- byte strobes
- read-only hardware-fed registers
- SLVERR decode
- per-register write/read strobes for the downstream engine

It sits between the AXI interconnect and the peripheral core, one instance per AXI slave port.

Parameters:
DATA_WIDTH, 32, AXI data width; 32 or 64 only.
NUM_REGS, 4, number of registers, 1..64.
ADDR_WIDTH, 6, AXI address width; must be >= clog2(NUM_REGS)+clog2(DATA_WIDTH/8).
RO_MASK, 0, NUM_REGS-bit; bit i=1 makes reg i read-only, value taken from hw_in slice i.
RESET_VAL, 0, DATA_WIDTH-bit reset value for every writable register.

Ports:
ACLK  in  1  clock, all logic rising-edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  DATA_WIDTH  write data.
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  DATA_WIDTH  read data.
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH].
hw_in  in  NUM_REGS*DATA_WIDTH  flattened values for RO registers; slices for writable registers are unused.
wr_pulse  out  NUM_REGS  one-cycle strobe, bit i set when reg i commits an accepted write.
rd_pulse  out  NUM_REGS  one-cycle strobe, bit i set on AR handshake to reg i.

Behaviour:
Reset (ARESET=1, asynchronous):
- AWREADY=WREADY=ARREADY=0.
- BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0.
- Writable registers=RESET_VAL; wr_pulse=rd_pulse=0.
- aw_seen/w_seen cleared.
- First cycle after release: AWREADY=WREADY=ARREADY=1.
- Reset mid-transaction drops BVALID/RVALID immediately; the pending write is lost and no register changes.

Address decode:
- idx = addr[ADDR_WIDTH-1:ADDR_LSB], where ADDR_LSB = clog2(DATA_WIDTH/8).
- Low ADDR_LSB bits are ignored.
- idx >= NUM_REGS is out of range.

Write channel:
- AW and W are accepted independently, in any order or in the same cycle.
- AWREADY = !aw_seen & !BVALID; WREADY = !w_seen & !BVALID.
- Captured address, data and strobe are held in registers.
- Commit edge is the edge at which both have been seen, including an edge where the second (or both) handshake occurs.
- At the commit edge:
  - In-range writable reg: each byte b updated where WSTRB[b]=1; BRESP=00; wr_pulse[idx]=1 for exactly the following cycle.
  - Read-only reg or out of range: no update, no pulse, BRESP=10.
  - BVALID is set and the seen flags are cleared.
- BVALID holds with stable BRESP until BREADY; it clears at the handshake edge.
- No new AW/W is accepted while BVALID=1.
- Minimum latency: AW+W in cycle N gives BVALID in N+1 and reg_out updated in N+1.
- WSTRB=0 is a legal no-op write: OKAY, wr_pulse still fires.

Read channel:
- ARREADY = !RVALID.
- At the AR handshake edge:
  - RDATA = reg i (RO: hw_in slice sampled that edge); out of range gives RDATA=0, RRESP=10.
  - RVALID is set; rd_pulse[idx]=1 next cycle, in range only.
- RVALID/RDATA/RRESP hold until RREADY; clear at the handshake edge.
- One outstanding read, one outstanding write; the two channels are fully concurrent.

Simultaneous events:
- Same-edge AR handshake and write commit to the same register: RDATA returns the pre-write value.
- BREADY/RREADY held high: back-to-back transactions every 2 cycles per channel.

Test Plan:
- Sequential write/readback, NUM_REGS=4: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back -> same values, all BRESP/RRESP=00, wr_pulse bits 0..3 each one cycle.
- Strobes: reg0=0x11223344, write 0xAABBCCDD WSTRB=0101 -> read 0x11BB33DD.
- Channel ordering: W two cycles before AW, then AW alone; BREADY low 5 cycles -> single commit, BVALID held 5 cycles, AWREADY/WREADY low during hold.
- Errors, NUM_REGS=4, RO_MASK=4'b0100, hw_in reg2=0xCAFEF00D:
  - write 0x8 -> BRESP=10, read 0x8 -> 0xCAFEF00D OKAY.
  - read 0x10 -> RDATA=0, RRESP=10, no rd_pulse.
- Concurrency: AR to 0x4 on the same edge reg1 commits 0x55 over 0x2 -> RDATA=0x2; next read -> 0x55.
- Reset mid-op: assert ARESET while BVALID=1 and RVALID=1 -> both drop within the same cycle, regs=RESET_VAL; DATA_WIDTH=64, NUM_REGS=8 rerun of the sequential test at stride 0x8 passes.
